// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 UART receiver with sticky rdy flag and framing-error report
//
// Recovers 8-data-bit, no-parity, one-stop-bit bytes from an asynchronous RX
// line. The line is synchronized through two flops and sampled mid-bit by a
// down-counting baud counter.
//
// Parameters:
//   BAUD_DIV  clk cycles per bit (must be >= 8)
//   CNT_W     baud counter width (2**CNT_W > BAUD_DIV)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   RX       in   serial input, idle high, asynchronous to clk
//   clr_rdy  in   consumer acknowledge; clears rdy on the next edge
//   rx_data  out  last correctly framed byte (LSB received first)
//   rdy      out  byte available, sticky until cleared or next start bit
//   frm_err  out  last frame had stop bit 0, sticky until next start bit
module uart_rx_8n1 #(
    parameter int BAUD_DIV = 2604,
    parameter int CNT_W    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(BAUD_DIV - 1);

    state_t           state;
    logic             rx_m;
    logic             rx_s;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;

    // Two-flop synchronizer; resets to the idle (high) line level so a reset
    // never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rdy      <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            // Acknowledge first; a set from the STOP state below overrides it.
            if (clr_rdy) begin
                rdy <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state    <= S_START;
                        baud_cnt <= HALF_RELOAD;
                        rdy      <= 1'b0;
                        frm_err  <= 1'b0;
                    end
                end

                S_START: begin
                    if (baud_cnt == '0) begin
                        if (rx_s) begin
                            // Line went back high by mid-start: treat as a glitch.
                            state <= S_IDLE;
                        end else begin
                            state    <= S_DATA;
                            bit_cnt  <= '0;
                            baud_cnt <= FULL_RELOAD;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (baud_cnt == '0) begin
                        shreg    <= {rx_s, shreg[7:1]};
                        baud_cnt <= FULL_RELOAD;
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (baud_cnt == '0) begin
                        if (rx_s) begin
                            rx_data <= shreg;
                            rdy     <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            frm_err <= 1'b1;
                            state   <= S_BREAK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end

                S_BREAK: begin
                    // Wait for the line to return high so a held-low line is
                    // not mistaken for a stream of start bits.
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb/tb_uart_rx_8n1.sv - self-checking bench for uart_rx_8n1
module tb_uart_rx_8n1;

    localparam int DIV      = 16;
    localparam int LAT      = 9 * DIV + DIV / 2 + 3;  // 155
    localparam int DIV2     = 2604;
    localparam int SLOW_LEN = 2656;                    // 2604 * 1.02
    localparam int FAST_LEN = 2552;                    // 2604 * 0.98

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    logic       rx2;
    logic       clr2;
    logic [7:0] rx_data2;
    logic       rdy2;
    logic       frm_err2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_8n1 #(.BAUD_DIV(DIV), .CNT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (rx),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    uart_rx_8n1 #(.BAUD_DIV(DIV2), .CNT_W(12)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .RX      (rx2),
        .clr_rdy (clr2),
        .rx_data (rx_data2),
        .rdy     (rdy2),
        .frm_err (frm_err2)
    );

    typedef struct {
        logic [7:0] d;
        logic       sb;
        logic [7:0] exp_data;
        logic       exp_rdy;
        logic       exp_frm;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_lat(input string name, input int act, input int exp);
        n_chk++;
        if (act < exp - 1 || act > exp + 1) begin
            n_err++;
            $display("FAIL %s: rdy rose at %0d clks, expected %0d +/-1", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        idle(1);
        clr_rdy = 1'b0;
    endtask

    // Drives one frame bit-accurately (len clks per bit), starting at the
    // current posedge+1 phase. rise/fall report the cycle (counted from the
    // start edge) at which rdy first rose/fell, or -1. clr_rdy is held high
    // across edge number clr_at when clr_at > 0 (first receiver only).
    task automatic send(input logic [7:0] d, input logic sb, input int len,
                        input bit which, input int clr_at,
                        output int rise, output int fall);
        logic [9:0] bits;
        logic       prev;
        logic       cur;
        int         cyc;
        bits = {sb, d, 1'b0};
        prev = which ? rdy2 : rdy;
        rise = -1;
        fall = -1;
        cyc  = 0;
        for (int i = 0; i < 10; i++) begin
            if (which) rx2 = bits[i];
            else       rx  = bits[i];
            repeat (len) begin
                @(posedge clk);
                cyc++;
                #1;
                if (!which && cyc == clr_at - 1) clr_rdy = 1'b1;
                if (!which && cyc == clr_at)     clr_rdy = 1'b0;
                cur = which ? rdy2 : rdy;
                if (cur && !prev && rise < 0) rise = cyc;
                if (!cur && prev && fall < 0) fall = cyc;
                prev = cur;
            end
        end
    endtask

    int rise;
    int fall;

    initial begin
        vt[0] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vt[1] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vt[2] = '{8'h5A, 1'b0, 8'hFF, 1'b0, 1'b1};
        vt[3] = '{8'h81, 1'b1, 8'h81, 1'b1, 1'b0};
        vt[4] = '{8'hC3, 1'b0, 8'h81, 1'b0, 1'b1};

        rst     = 1'b1;
        rx      = 1'b1;
        rx2     = 1'b1;
        clr_rdy = 1'b0;
        clr2    = 1'b0;
        idle(3);
        chk("reset rx_data", rx_data, 8'h00);
        chk("reset rdy", rdy, 0);
        chk("reset frm_err", frm_err, 0);
        chk("reset rx_data2", rx_data2, 8'h00);
        rst = 1'b0;
        idle(5);

        // Single byte, latency and acknowledge.
        send(8'h67, 1'b1, DIV, 1'b0, -5, rise, fall);
        chk_lat("t1 latency", rise, LAT);
        chk("t1 rx_data", rx_data, 8'h67);
        chk("t1 rdy", rdy, 1);
        chk("t1 frm_err", frm_err, 0);
        pulse_clr();
        chk("t1 rdy after clr", rdy, 0);
        chk("t1 rx_data held", rx_data, 8'h67);
        pulse_clr();
        chk("t1 clr with rdy=0", rdy, 0);

        // Short low glitch on idle line.
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        chk("t3 rdy", rdy, 0);
        chk("t3 rx_data", rx_data, 8'h67);
        chk("t3 frm_err", frm_err, 0);

        // Back-to-back frames without acknowledge.
        send(8'h73, 1'b1, DIV, 1'b0, -5, rise, fall);
        chk_lat("t2a latency", rise, LAT);
        chk("t2a rx_data", rx_data, 8'h73);
        send(8'hA5, 1'b1, DIV, 1'b0, -5, rise, fall);
        chk_lat("t2b rdy drop", fall, 3);
        chk_lat("t2b latency", rise, LAT);
        chk("t2b rx_data", rx_data, 8'hA5);
        chk("t2b rdy", rdy, 1);
        pulse_clr();

        // Framing error, held-low line, then recovery.
        send(8'h55, 1'b0, DIV, 1'b0, -5, rise, fall);
        chk("t4 no rdy rise", rise, -1);
        chk("t4 frm_err", frm_err, 1);
        chk("t4 rdy", rdy, 0);
        chk("t4 rx_data old", rx_data, 8'hA5);
        idle(40);
        chk("t4 frm_err held low", frm_err, 1);
        rx = 1'b1;
        idle(20);
        send(8'h3C, 1'b1, DIV, 1'b0, -5, rise, fall);
        chk_lat("t4 recover latency", rise, LAT);
        chk("t4 recover rx_data", rx_data, 8'h3C);
        chk("t4 recover frm_err", frm_err, 0);
        pulse_clr();

        // Table of frames.
        for (int i = 0; i < 5; i++) begin
            send(vt[i].d, vt[i].sb, DIV, 1'b0, -5, rise, fall);
            rx = 1'b1;
            idle(20);
            chk($sformatf("vec%0d rx_data", i), rx_data, vt[i].exp_data);
            chk($sformatf("vec%0d rdy", i), rdy, vt[i].exp_rdy);
            chk($sformatf("vec%0d frm_err", i), frm_err, vt[i].exp_frm);
            if (vt[i].exp_rdy) chk_lat($sformatf("vec%0d latency", i), rise, LAT);
            else               chk($sformatf("vec%0d no rdy", i), rise, -1);
            pulse_clr();
        end

        // Reset in the middle of a 0xFF frame.
        rx = 1'b0;
        idle(DIV);
        rx = 1'b1;
        idle(40);
        rst = 1'b1;
        #1;
        chk("t5 rx_data in reset", rx_data, 8'h00);
        chk("t5 rdy in reset", rdy, 0);
        chk("t5 frm_err in reset", frm_err, 0);
        idle(3);
        chk("t5 rx_data still reset", rx_data, 8'h00);
        rst = 1'b0;
        idle(5);
        send(8'h81, 1'b1, DIV, 1'b0, -5, rise, fall);
        chk_lat("t5 latency", rise, LAT);
        chk("t5 rx_data", rx_data, 8'h81);
        chk("t5 rdy", rdy, 1);
        pulse_clr();

        // clr_rdy on the exact STOP-sample edge: set wins.
        send(8'h67, 1'b1, DIV, 1'b0, LAT, rise, fall);
        chk("t6 set wins rdy", rdy, 1);
        chk("t6 rx_data", rx_data, 8'h67);
        pulse_clr();
        chk("t6 rdy after clr", rdy, 0);

        // Baud mismatch on the full-rate receiver.
        send(8'h67, 1'b1, SLOW_LEN, 1'b1, -5, rise, fall);
        chk("tol slow rx_data", rx_data2, 8'h67);
        chk("tol slow rdy", rdy2, 1);
        chk("tol slow frm_err", frm_err2, 0);
        clr2 = 1'b1;
        idle(1);
        clr2 = 1'b0;
        chk("tol clr rdy2", rdy2, 0);
        send(8'h98, 1'b1, FAST_LEN, 1'b1, -5, rise, fall);
        idle(DIV2);
        chk("tol fast rx_data", rx_data2, 8'h98);
        chk("tol fast rdy", rdy2, 1);
        chk("tol fast frm_err", frm_err2, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
